// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversample limits and word-length codes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [3:0] OSM16_MAX = 4'd15;
  localparam logic [3:0] OSM13_MAX = 4'd12;
  localparam logic [3:0] OSM16_MID = 4'd7;
  localparam logic [3:0] OSM13_MID = 4'd6;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Index of the final data bit for a given word-length code (5 bits -> index 4).
  function automatic logic [2:0] lastBitIdx(input logic [1:0] wlsCode);
    return 3'(wlsCode) + 3'd4;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous serial input; resets to the idle-high level.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_pclk,
  input  logic i_preset,
  input  logic i_rxd,
  output logic o_rxd
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxd};
    end
  end

  assign o_rxd = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start/data/parity/stop recovery with parity, framing,
// break and overrun reporting into the RX FIFO interface.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       bclk,
  input  logic       uart_rxd,
  input  logic       osm_sel,
  input  logic       eps,
  input  logic       pen,
  input  logic       stb,
  input  logic [1:0] wls,
  input  logic       rx_full_status,
  output logic       rx_wr,
  output logic [7:0] rx_data,
  output logic       rx_pe,
  output logic       rx_fe,
  output logic       rx_bi,
  output logic       rx_oe
);

  uart_state_e r_state, w_nextState;
  logic [3:0]  r_count;
  logic [2:0]  r_dataCnt;
  logic [7:0]  r_data;
  logic        r_parBit;
  logic        r_idleSeen;
  logic        r_cfgOsm, r_cfgEps, r_cfgPen;
  logic [1:0]  r_cfgWls;

  logic        w_rxdS;
  logic [3:0]  w_max, w_mid;
  logic        w_startDet, w_sample, w_lastBit;
  logic        w_expPar, w_pe, w_fe, w_bi;
  logic        w_unused;

  // The stop-bit setting only matters to the transmitter.
  assign w_unused = stb;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_pclk   (pclk),
    .i_preset (preset),
    .i_rxd    (uart_rxd),
    .o_rxd    (w_rxdS)
  );

  always_ff @(posedge pclk) begin
    if (preset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_startDet) w_nextState = ST_START;
      ST_START:  if (w_sample) w_nextState = w_rxdS ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_sample && w_lastBit) w_nextState = r_cfgPen ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_sample) w_nextState = ST_STOP;
      ST_STOP:   if (w_sample) w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // A start needs the line to have been seen high first, so a held-low break cannot retrigger.
  always_comb begin
    w_max      = r_cfgOsm ? OSM13_MAX : OSM16_MAX;
    w_mid      = r_cfgOsm ? OSM13_MID : OSM16_MID;
    w_startDet = bclk && (r_state == ST_IDLE) && !w_rxdS && r_idleSeen;
    w_sample   = 1'b0;
    if (bclk) begin
      if (r_state == ST_START)
        w_sample = (r_count == w_mid);
      else if (r_state inside {ST_DATA, ST_PARITY, ST_STOP})
        w_sample = (r_count == w_max);
    end
    w_lastBit = (r_dataCnt == lastBitIdx(r_cfgWls));
    w_expPar  = r_cfgEps ? ^r_data : ~^r_data;
    w_pe      = r_cfgPen && (r_parBit != w_expPar);
    w_fe      = !w_rxdS;
    w_bi      = (r_data == 8'h00) && (!r_parBit || !r_cfgPen) && !w_rxdS;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_count    <= '0;
      r_dataCnt  <= '0;
      r_data     <= '0;
      r_parBit   <= 1'b0;
      r_idleSeen <= 1'b0;
      r_cfgOsm   <= 1'b0;
      r_cfgEps   <= 1'b0;
      r_cfgPen   <= 1'b0;
      r_cfgWls   <= WLS_8;
      rx_wr      <= 1'b0;
      rx_data    <= '0;
      rx_pe      <= 1'b0;
      rx_fe      <= 1'b0;
      rx_bi      <= 1'b0;
      rx_oe      <= 1'b0;
    end else begin
      rx_wr <= 1'b0;
      rx_oe <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_rxdS) r_idleSeen <= 1'b1;
        if (w_startDet) begin
          r_idleSeen <= 1'b0;
          r_count    <= '0;
          r_data     <= '0;
          r_parBit   <= 1'b0;
          r_cfgOsm   <= osm_sel;
          r_cfgEps   <= eps;
          r_cfgPen   <= pen;
          r_cfgWls   <= wls;
        end
      end else if (bclk) begin
        r_count <= w_sample ? 4'd0 : r_count + 4'd1;
        if (w_sample) begin
          case (r_state)
            ST_START:  r_dataCnt <= '0;
            ST_DATA: begin
              r_data[r_dataCnt] <= w_rxdS;
              r_dataCnt         <= r_dataCnt + 3'd1;
            end
            ST_PARITY: r_parBit <= w_rxdS;
            ST_STOP: begin
              // Commit is evaluated at the stop-bit centre; a full FIFO turns it into an overrun.
              if (rx_full_status) begin
                rx_oe <= 1'b1;
              end else begin
                rx_wr   <= 1'b1;
                rx_data <= w_bi ? 8'h00 : r_data;
                rx_pe   <= w_pe;
                rx_fe   <= w_fe;
                rx_bi   <= w_bi;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: serial frames driven on uart_rxd, expected FIFO writes queued.
module tb_uart_receiver;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
  } rx_rec_t;

  logic       pclk = 1'b0;
  logic       preset, uart_rxd, osm_sel, eps, pen, stb, rx_full_status;
  logic [1:0] wls;
  logic       bclk;
  logic       bclkEn = 1'b1;
  int         bclkCnt = 0;
  logic       rx_wr, rx_pe, rx_fe, rx_bi, rx_oe;
  logic [7:0] rx_data;

  rx_rec_t expQ[$];
  rx_rec_t obsQ[$];
  int wrCount = 0;
  int oeCount = 0;
  int vectors = 0;
  int miscompares = 0;
  int bitCycles = 64;

  uart_receiver #(.SYNC_STAGES(2)) dut (
    .pclk           (pclk),
    .preset         (preset),
    .bclk           (bclk),
    .uart_rxd       (uart_rxd),
    .osm_sel        (osm_sel),
    .eps            (eps),
    .pen            (pen),
    .stb            (stb),
    .wls            (wls),
    .rx_full_status (rx_full_status),
    .rx_wr          (rx_wr),
    .rx_data        (rx_data),
    .rx_pe          (rx_pe),
    .rx_fe          (rx_fe),
    .rx_bi          (rx_bi),
    .rx_oe          (rx_oe)
  );

  always #5 pclk = ~pclk;

  // Oversample tick: one pclk cycle in four, stoppable to freeze the receiver.
  always @(posedge pclk) begin
    if (bclkEn) bclkCnt <= (bclkCnt == 3) ? 0 : bclkCnt + 1;
  end
  assign bclk = bclkEn && (bclkCnt == 3);

  always @(negedge pclk) begin
    if (rx_wr) begin
      obsQ.push_back({rx_data, rx_pe, rx_fe, rx_bi});
      wrCount <= wrCount + 1;
    end
    if (rx_oe) oeCount <= oeCount + 1;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic settle();
    @(negedge pclk);
    #1;
  endtask

  task automatic driveBit(input logic v);
    uart_rxd = v;
    repeat (bitCycles) @(negedge pclk);
  endtask

  task automatic sendFrame(input logic [7:0] d, input int nbits, input logic withPar,
                           input logic parBit, input logic stopBit, input logic flipWls);
    logic [1:0] savedWls;
    savedWls = wls;
    driveBit(1'b0);
    if (flipWls) wls = ~wls;
    for (int i = 0; i < nbits; i++) driveBit(d[i]);
    if (withPar) driveBit(parBit);
    driveBit(stopBit);
    if (flipWls) wls = savedWls;
    uart_rxd = 1'b1;
  endtask

  task automatic popPair(output rx_rec_t e, output rx_rec_t o, output bit got);
    int n;
    n = 0;
    got = 1'b0;
    e = '0;
    o = '0;
    while (obsQ.size() == 0 && n < 400) begin
      @(negedge pclk);
      n++;
    end
    if (expQ.size() > 0) e = expQ.pop_front();
    if (obsQ.size() > 0) begin
      o = obsQ.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (5) @(negedge pclk);
    vectors++;
    if ({rx_wr, rx_data, rx_pe, rx_fe, rx_bi, rx_oe} !== 13'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h want 0", {rx_wr, rx_data, rx_pe, rx_fe, rx_bi, rx_oe});
    end
    preset = 1'b0;
    repeat (20) @(negedge pclk);
  endtask

  task automatic test_basic_8n1();
    rx_rec_t e, o;
    bit got;
    int w0;
    w0 = wrCount;
    expQ.push_back({8'hA5, 1'b0, 1'b0, 1'b0});
    sendFrame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    popPair(e, o, got);
    vectors++;
    if (!got || o !== e) begin
      miscompares++;
      $display("[TB] FAIL 8n1_A5: got %h want %h (seen=%0d)", o, e, got);
    end
    repeat (bitCycles) @(negedge pclk);
    settle();
    vectors++;
    if (wrCount - w0 != 1) begin
      miscompares++;
      $display("[TB] FAIL 8n1_write_count: got %0d want 1", wrCount - w0);
    end
  endtask

  task automatic test_parity();
    rx_rec_t e, o;
    bit got;
    wls = 2'b10;
    pen = 1'b1;
    eps = 1'b1;
    // 0x35 over 7 bits has four ones: even parity bit 0, odd parity bit 1.
    expQ.push_back({8'h35, 1'b1, 1'b0, 1'b0});
    sendFrame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0);
    popPair(e, o, got);
    vectors++;
    if (!got || o !== e) begin
      miscompares++;
      $display("[TB] FAIL even_parity_bad: got %h want %h (seen=%0d)", o, e, got);
    end
    expQ.push_back({8'h35, 1'b0, 1'b0, 1'b0});
    sendFrame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    popPair(e, o, got);
    vectors++;
    if (!got || o !== e) begin
      miscompares++;
      $display("[TB] FAIL even_parity_good: got %h want %h (seen=%0d)", o, e, got);
    end
    eps = 1'b0;
    expQ.push_back({8'h35, 1'b0, 1'b0, 1'b0});
    sendFrame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0);
    popPair(e, o, got);
    vectors++;
    if (!got || o !== e) begin
      miscompares++;
      $display("[TB] FAIL odd_parity_good: got %h want %h (seen=%0d)", o, e, got);
    end
    pen = 1'b0;
    repeat (bitCycles) @(negedge pclk);
  endtask

  task automatic test_framing_break();
    rx_rec_t e, o;
    bit got;
    int w0;
    wls = 2'b00;
    expQ.push_back({8'h1F, 1'b0, 1'b1, 1'b0});
    sendFrame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    popPair(e, o, got);
    vectors++;
    if (!got || o !== e) begin
      miscompares++;
      $display("[TB] FAIL framing_1F: got %h want %h (seen=%0d)", o, e, got);
    end
    repeat (2 * bitCycles) @(negedge pclk);
    w0 = wrCount;
    expQ.push_back({8'h00, 1'b0, 1'b1, 1'b1});
    uart_rxd = 1'b0;
    repeat (14 * bitCycles) @(negedge pclk);
    popPair(e, o, got);
    vectors++;
    if (!got || o !== e) begin
      miscompares++;
      $display("[TB] FAIL break_record: got %h want %h (seen=%0d)", o, e, got);
    end
    settle();
    vectors++;
    if (wrCount - w0 != 1) begin
      miscompares++;
      $display("[TB] FAIL break_write_count: got %0d want 1", wrCount - w0);
    end
    uart_rxd = 1'b1;
    repeat (2 * bitCycles) @(negedge pclk);
    expQ.push_back({8'h0A, 1'b0, 1'b0, 1'b0});
    sendFrame(8'h0A, 5, 1'b0, 1'b0, 1'b1, 1'b0);
    popPair(e, o, got);
    vectors++;
    if (!got || o !== e) begin
      miscompares++;
      $display("[TB] FAIL after_break_0A: got %h want %h (seen=%0d)", o, e, got);
    end
    wls = 2'b11;
    repeat (bitCycles) @(negedge pclk);
  endtask

  task automatic test_false_start();
    rx_rec_t e, o;
    bit got;
    int w0;
    osm_sel = 1'b1;
    bitCycles = 52;
    w0 = wrCount;
    uart_rxd = 1'b0;
    repeat (12) @(negedge pclk);
    uart_rxd = 1'b1;
    repeat (12 * bitCycles) @(negedge pclk);
    settle();
    vectors++;
    if (wrCount != w0) begin
      miscompares++;
      $display("[TB] FAIL glitch_no_write: got %0d writes want 0", wrCount - w0);
    end
    expQ.push_back({8'hC3, 1'b0, 1'b0, 1'b0});
    sendFrame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    popPair(e, o, got);
    vectors++;
    if (!got || o !== e) begin
      miscompares++;
      $display("[TB] FAIL osm13_C3: got %h want %h (seen=%0d)", o, e, got);
    end
    osm_sel = 1'b0;
    bitCycles = 64;
    repeat (bitCycles) @(negedge pclk);
  endtask

  task automatic test_overrun();
    rx_rec_t e, o;
    bit got;
    int w0, oe0;
    w0 = wrCount;
    oe0 = oeCount;
    rx_full_status = 1'b1;
    sendFrame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    rx_full_status = 1'b0;
    settle();
    vectors++;
    if (wrCount != w0) begin
      miscompares++;
      $display("[TB] FAIL overrun_no_write: got %0d writes want 0", wrCount - w0);
    end
    vectors++;
    if (oeCount - oe0 != 1) begin
      miscompares++;
      $display("[TB] FAIL overrun_pulse: got %0d pulses want 1", oeCount - oe0);
    end
    vectors++;
    if (rx_data !== 8'hC3) begin
      miscompares++;
      $display("[TB] FAIL overrun_data_held: got %h want c3", rx_data);
    end
    expQ.push_back({8'h3C, 1'b0, 1'b0, 1'b0});
    sendFrame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    popPair(e, o, got);
    vectors++;
    if (!got || o !== e) begin
      miscompares++;
      $display("[TB] FAIL after_overrun_3C: got %h want %h (seen=%0d)", o, e, got);
    end
  endtask

  task automatic test_back_to_back();
    rx_rec_t e, o;
    bit got;
    expQ.push_back({8'h12, 1'b0, 1'b0, 1'b0});
    expQ.push_back({8'hED, 1'b0, 1'b0, 1'b0});
    sendFrame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    sendFrame(8'hED, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      popPair(e, o, got);
      vectors++;
      if (!got || o !== e) begin
        miscompares++;
        $display("[TB] FAIL back_to_back_%0d: got %h want %h (seen=%0d)", k, o, e, got);
      end
    end
  endtask

  task automatic test_reset_midframe();
    rx_rec_t e, o;
    bit got;
    int w0, oe0;
    w0 = wrCount;
    oe0 = oeCount;
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    preset = 1'b1;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    for (int i = 0; i < 7; i++) driveBit(1'b1);
    settle();
    vectors++;
    if (wrCount != w0 || oeCount != oe0) begin
      miscompares++;
      $display("[TB] FAIL abort_no_pulses: got wr=%0d oe=%0d want 0 0", wrCount - w0, oeCount - oe0);
    end
    vectors++;
    if ({rx_data, rx_pe, rx_fe, rx_bi} !== 11'h0) begin
      miscompares++;
      $display("[TB] FAIL abort_outputs: got %h want 0", {rx_data, rx_pe, rx_fe, rx_bi});
    end
    expQ.push_back({8'h81, 1'b0, 1'b0, 1'b0});
    sendFrame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    popPair(e, o, got);
    vectors++;
    if (!got || o !== e) begin
      miscompares++;
      $display("[TB] FAIL latched_wls_81: got %h want %h (seen=%0d)", o, e, got);
    end
  endtask

  task automatic test_bclk_freeze();
    int w0;
    repeat (bitCycles) @(negedge pclk);
    w0 = wrCount;
    bclkEn = 1'b0;
    sendFrame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    vectors++;
    if (wrCount != w0 || rx_data !== 8'h81) begin
      miscompares++;
      $display("[TB] FAIL frozen_no_change: got wr=%0d data=%h want 0 81", wrCount - w0, rx_data);
    end
    bclkEn = 1'b1;
    repeat (2 * bitCycles) @(negedge pclk);
    settle();
    vectors++;
    if (obsQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL no_extra_writes: got %0d unexpected want 0", obsQ.size());
    end
  endtask

  initial begin
    preset = 1'b1;
    uart_rxd = 1'b1;
    osm_sel = 1'b0;
    eps = 1'b0;
    pen = 1'b0;
    stb = 1'b0;
    wls = 2'b11;
    rx_full_status = 1'b0;
    test_reset();
    test_basic_8n1();
    test_parity();
    test_framing_break();
    test_false_start();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_bclk_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
